// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running binary counter output. It locks onto a run of
// valid +1 steps, then flags skips (err_pulse_o, saturating err_count_o) and correct
// all-ones -> zero steps (wrap_pulse_o).
// Optional build macro COUNT_CHK_DOWN_EN adds dir_i (1 = up, 0 = down) for down-counters.
// Reset is synchronous and active-high.

module count_seq_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] q_in_i,
    input  logic             q_valid_i,
`ifdef COUNT_CHK_DOWN_EN
    input  logic             dir_i,
`endif
    output logic             locked_o,
    output logic [WIDTH-1:0] expected_o,
    output logic             err_pulse_o,
    output logic             wrap_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    // Run value at which the next GOOD step completes the lock.
    localparam logic [3:0] LockLast = 4'(LOCK_CNT - 1);

    state_e           state_q;
    logic             have_prev_q;
    logic [3:0]       run_q;
    logic [WIDTH-1:0] prev_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_pulse_q;
    logic [ERR_W-1:0] err_count_q;

    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;
    logic             up;
    logic             dir_chg;
    logic             step_good;
    logic             step_wrap;

`ifdef COUNT_CHK_DOWN_EN
    logic dir_q;

    // Remember last direction so a change can drop the lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_i;
        end
    end

    assign up         = dir_i;
    assign dir_chg    = (dir_i != dir_q);
    assign expected_o = dir_q ? prev_inc : prev_dec;
`else
    assign up         = 1'b1;
    assign dir_chg    = 1'b0;
    assign expected_o = prev_inc;
`endif

    // Classify the incoming sample against the last accepted value.
    always_comb begin
        prev_inc  = prev_q + WIDTH'(1);
        prev_dec  = prev_q - WIDTH'(1);
        step_good = 1'b0;
        step_wrap = 1'b0;
        if (up) begin
            step_good = (q_in_i == prev_inc);
            step_wrap = (prev_q == '1) && (q_in_i == '0);
        end else begin
            step_good = (q_in_i == prev_dec);
            step_wrap = (prev_q == '0) && (q_in_i == '1);
        end
    end

    // Tracking FSM with registered flags and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StSearch;
            have_prev_q  <= 1'b0;
            run_q        <= 4'd0;
            prev_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            if (q_valid_i) begin
                if (!have_prev_q || dir_chg) begin
                    // Seed: first sample, or direction flipped; no error either way.
                    prev_q      <= q_in_i;
                    have_prev_q <= 1'b1;
                    run_q       <= 4'd0;
                    state_q     <= StSearch;
                    locked_q    <= 1'b0;
                end else if (q_in_i == prev_q) begin
                    // Stalled counter: tolerated, nothing changes.
                end else if (step_good) begin
                    prev_q <= q_in_i;
                    if (state_q == StLocked) begin
                        wrap_pulse_q <= step_wrap;
                    end else begin
                        run_q <= run_q + 4'd1;
                        if (run_q == LockLast) begin
                            state_q  <= StLocked;
                            locked_q <= 1'b1;
                        end
                    end
                end else begin
                    // BAD step: the offending value seeds the relock.
                    prev_q <= q_in_i;
                    run_q  <= 4'd0;
                    if (state_q == StLocked) begin
                        err_pulse_q <= 1'b1;
                        state_q     <= StSearch;
                        locked_q    <= 1'b0;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + ERR_W'(1);
                        end
                    end
                end
            end else if (dir_chg && state_q == StLocked) begin
                state_q  <= StSearch;
                locked_q <= 1'b0;
                run_q    <= 4'd0;
            end
        end
    end

    assign locked_o     = locked_q;
    assign err_pulse_o  = err_pulse_q;
    assign wrap_pulse_o = wrap_pulse_q;
    assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios followed by random counter traffic,
// compared every cycle against an integer reference model. A second instance with a
// 2-bit error counter exercises saturation.

module tb_count_seq_checker;

    localparam int M    = 16;
    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       q_valid;
    logic       dir;

    logic       locked, err_pulse, wrap_pulse;
    logic [3:0] expected;
    logic [7:0] err_count;
    logic       locked_b, err_pulse_b, wrap_pulse_b;
    logic [3:0] expected_b;
    logic [1:0] err_count_b;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_have, m_prev, m_run, m_locked, m_err, m_dir_last, m_ep, m_wp;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .q_in_i      (q_in),
        .q_valid_i   (q_valid),
`ifdef COUNT_CHK_DOWN_EN
        .dir_i       (dir),
`endif
        .locked_o    (locked),
        .expected_o  (expected),
        .err_pulse_o (err_pulse),
        .wrap_pulse_o(wrap_pulse),
        .err_count_o (err_count)
    );

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .q_in_i      (q_in),
        .q_valid_i   (q_valid),
`ifdef COUNT_CHK_DOWN_EN
        .dir_i       (dir),
`endif
        .locked_o    (locked_b),
        .expected_o  (expected_b),
        .err_pulse_o (err_pulse_b),
        .wrap_pulse_o(wrap_pulse_b),
        .err_count_o (err_count_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_locked = 0; m_err = 0;
        m_dir_last = 1; m_ep = 0; m_wp = 0;
    endtask

    task automatic model_step(input int valid, input int v, input int d);
        int chg;
        int nxt;
        chg = (d != m_dir_last);
        m_dir_last = d;
        m_ep = 0;
        m_wp = 0;
        nxt = d ? (m_prev + 1) % M : (m_prev + M - 1) % M;
        if (valid != 0) begin
            if (m_have == 0 || chg != 0) begin
                m_prev = v; m_have = 1; m_run = 0; m_locked = 0;
            end else if (v == m_prev) begin
                // stall
            end else if (v == nxt) begin
                if (m_locked != 0) begin
                    m_wp = d ? (m_prev == M - 1 && v == 0) : (m_prev == 0 && v == M - 1);
                end else begin
                    m_run++;
                    if (m_run >= LOCK) m_locked = 1;
                end
                m_prev = v;
            end else begin
                if (m_locked != 0) begin
                    m_ep = 1; m_err++; m_locked = 0;
                end
                m_prev = v;
                m_run = 0;
            end
        end else if (chg != 0 && m_locked != 0) begin
            m_locked = 0;
            m_run = 0;
        end
    endtask

    task automatic compare_all();
        int exp_next;
        exp_next = m_dir_last ? (m_prev + 1) % M : (m_prev + M - 1) % M;
        check_eq("locked",     locked,      m_locked);
        check_eq("expected",   expected,    exp_next);
        check_eq("err_pulse",  err_pulse,   m_ep);
        check_eq("wrap_pulse", wrap_pulse,  m_wp);
        check_eq("err_count",  err_count,   imin(m_err, 255));
        check_eq("locked_b",   locked_b,    m_locked);
        check_eq("err_count_b", err_count_b, imin(m_err, 3));
    endtask

    task automatic step(input logic valid, input int v, input logic d);
        q_valid = valid;
        q_in    = 4'(v);
        dir     = d;
        @(posedge clk);
        model_step(valid, v, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        check_eq("rst_expected", expected, 1);
        check_eq("rst_locked", locked, 0);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int r;
        logic d;
        int wraps;
        rst = 1'b0; q_in = '0; q_valid = 1'b0; dir = 1'b1;
        model_reset();

        // T1: lock after sampling 2, expected 4 after 3
        do_reset();
        step(1, 0, 1); step(1, 1, 1);
        step(1, 2, 1); check_eq("t1_lock", locked, 1);
        step(1, 3, 1); check_eq("t1_expected", expected, 4);

        // T2: wrap pulse exactly once across 14,15,0,1
        for (int i = 4; i <= 13; i++) step(1, i, 1);
        wraps = 0;
        step(1, 14, 1); wraps += wrap_pulse;
        step(1, 15, 1); wraps += wrap_pulse;
        step(1, 0, 1);  check_eq("t2_wrap", wrap_pulse, 1); wraps += wrap_pulse;
        step(1, 1, 1);  wraps += wrap_pulse;
        check_eq("t2_wraps", wraps, 1);
        check_eq("t2_errs", err_count, 0);

        // T3: skip 6->8 errors, then relock on 10
        for (int i = 2; i <= 6; i++) step(1, i, 1);
        step(1, 8, 1);
        check_eq("t3_err", err_pulse, 1);
        check_eq("t3_cnt", err_count, 1);
        check_eq("t3_unlock", locked, 0);
        step(1, 9, 1);
        step(1, 10, 1); check_eq("t3_relock", locked, 1);

        // T4: hold at 7 with gaps, no error
        do_reset();
        step(1, 5, 1); step(1, 6, 1); step(1, 7, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 7, 1);
            step(0, 3, 1);
        end
        step(1, 8, 1);
        check_eq("t4_locked", locked, 1);
        check_eq("t4_errs", err_count, 0);

        // T6: reset while locked at 9
        step(1, 9, 1);
        do_reset();
        check_eq("t6_errs", err_count, 0);

        // T5: five BAD steps with relocks between; small counter saturates at 3
        step(1, 0, 1); step(1, 1, 1); step(1, 2, 1);
        cnt = 2;
        for (int i = 0; i < 5; i++) begin
            cnt = (cnt + 5) % M;
            step(1, cnt, 1);
            cnt = (cnt + 1) % M; step(1, cnt, 1);
            cnt = (cnt + 1) % M; step(1, cnt, 1);
        end
        check_eq("t5_sat", err_count_b, 3);
        check_eq("t5_full", err_count, 5);

`ifdef COUNT_CHK_DOWN_EN
        // Down mode: 3,2,1,0,15 locks then wraps
        do_reset();
        step(1, 3, 0); step(1, 2, 0); step(1, 1, 0);
        check_eq("dn_lock", locked, 1);
        step(1, 0, 0);
        step(1, 15, 0); check_eq("dn_wrap", wrap_pulse, 1);
        // Direction change while locked drops lock without an error
        step(0, 0, 1);
        check_eq("dn_chg_lock", locked, 0);
        check_eq("dn_chg_err", err_pulse, 0);
`endif

        // Random counter traffic with stalls, skips, gaps and rare resets
        do_reset();
        cnt = 0;
        d = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
`ifdef COUNT_CHK_DOWN_EN
            if ($urandom_range(0, 49) == 0) d = ~d;
`endif
            if (r < 2) begin
                do_reset();
            end else if (r < 12) begin
                step(0, $urandom_range(0, 15), d);
            end else if (r < 22) begin
                step(1, cnt, d);
            end else if (r < 30) begin
                cnt = $urandom_range(0, 15);
                step(1, cnt, d);
            end else begin
                cnt = d ? (cnt + 1) % M : (cnt + M - 1) % M;
                step(1, cnt, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
